// File: rtl/pcs_sync_pkg.sv
// Shared definitions for 1000BASE-X code-group synchronization:
// special code-group constants, one-hot sync states and 8b/10b helpers.
package pcs_sync_pkg;

    // Special code-groups, abcdei_fghj with 'a' in bit 9 (RD- / RD+)
    localparam logic [9:0] K28_5_N = 10'b0011111010;
    localparam logic [9:0] K28_5_P = 10'b1100000101;
    localparam logic [9:0] K27_7_N = 10'b1101101000;
    localparam logic [9:0] K27_7_P = 10'b0010010111;
    localparam logic [9:0] K29_7_N = 10'b1011101000;
    localparam logic [9:0] K29_7_P = 10'b0100010111;
    localparam logic [9:0] K23_7_N = 10'b1110101000;
    localparam logic [9:0] K23_7_P = 10'b0001010111;

    // One-hot synchronization states
    typedef enum logic [12:0] {
        ST_LOS  = 13'h0001,
        ST_CD1  = 13'h0002,
        ST_AS1  = 13'h0004,
        ST_CD2  = 13'h0008,
        ST_AS2  = 13'h0010,
        ST_CD3  = 13'h0020,
        ST_SA1  = 13'h0040,
        ST_SA2  = 13'h0080,
        ST_SA2A = 13'h0100,
        ST_SA3  = 13'h0200,
        ST_SA3A = 13'h0400,
        ST_SA4  = 13'h0800,
        ST_SA4A = 13'h1000
    } sync_state_e;

    // 5b/6b sub-block for data code x under running disparity rd
    function automatic logic [5:0] enc6(input logic [4:0] x, input logic rd);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        // Unbalanced groups and the disparity-specific D.7 flip for RD+
        if (rd && (($countones(c) != 3) || (x == 5'd7))) c = ~c;
        return c;
    endfunction

    // 3b/4b sub-block for y under the disparity left by the 6b part
    function automatic logic [3:0] enc4(input logic [2:0] y, input logic rd, input logic [4:0] x);
        logic [3:0] c;
        logic       alt;
        // D.x.A7 replaces P7 where P7 would create a run of five
        alt = (!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            default: c = alt ? 4'b0111 : 4'b1110;
        endcase
        if (rd && (($countones(c) != 2) || (y == 3'd3))) c = ~c;
        return c;
    endfunction

    // True when code is a legal D code-group in either starting disparity
    function automatic logic is_d_code(input logic [9:0] code);
        logic found;
        logic rd_mid;
        found  = 1'b0;
        rd_mid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int x = 0; x < 32; x++) begin
                if (code[9:4] == enc6(5'(x), 1'(r))) begin
                    rd_mid = 1'(r) ^ ($countones(code[9:4]) != 3);
                    for (int y = 0; y < 8; y++) begin
                        if (code[3:0] == enc4(3'(y), rd_mid, 5'(x))) found = 1'b1;
                    end
                end
            end
        end
        return found;
    endfunction

    // Two-bit counter increment that sticks at its maximum
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

endpackage

// File: rtl/pcs_sync_cg_classifier.sv
// Combinational classification of one received code-group into
// comma, data or invalid. Running disparity is deliberately not tracked.
module pcs_cg_classifier
    import pcs_sync_pkg::*;
(
    input  logic [9:0] code,
    output logic       is_comma,
    output logic       is_data,
    output logic       is_invalid
);

    logic is_ctrl;

    // Decode the code-group against the K and D code sets
    always_comb begin
        is_comma   = (code == K28_5_N) || (code == K28_5_P);
        is_ctrl    = (code == K27_7_N) || (code == K27_7_P) ||
                     (code == K29_7_N) || (code == K29_7_P) ||
                     (code == K23_7_N) || (code == K23_7_P);
        is_data    = is_d_code(code);
        is_invalid = !(is_comma || is_ctrl || is_data);
    end

endmodule

// File: rtl/pcs_sync.sv
// 1000BASE-X PCS code-group synchronization: acquires comma alignment,
// monitors for errors, labels even/odd positions and forwards SUDI.
module pcs_sync
    import pcs_sync_pkg::*;
#(
    parameter int GOOD_CGS_MAX = 3,
    parameter int NUM_COMMAS   = 3
) (
    input  logic       RX_CLK,
    input  logic       mr_main_reset,
    input  logic       signal_detect,
    input  logic [9:0] rx_code_group,
    output logic [9:0] SUDI,
    output logic       rx_even,
    output logic       code_sync_status
);

    // The acquisition chain is built for three comma pairs; any other
    // setting never declares sync.
    localparam logic CHAIN_OK = (NUM_COMMAS == 3);
    localparam logic [1:0] GOOD_MAX = 2'(GOOD_CGS_MAX);

    logic        is_comma, is_data, is_invalid;
    logic        lbl_tog, cgbad, cggood;
    logic [1:0]  good_inc;
    sync_state_e state_q, state_d;
    logic [1:0]  good_cgs_q, good_cgs_d;
    logic        rx_even_q, rx_even_d;
    logic        sync_q, sync_d;
    logic [9:0]  sudi_q;

    pcs_cg_classifier u_cls (
        .code       (rx_code_group),
        .is_comma   (is_comma),
        .is_data    (is_data),
        .is_invalid (is_invalid)
    );

    // Next-state, parity label and good-group counter for this code-group
    always_comb begin
        state_d    = state_q;
        good_cgs_d = good_cgs_q;
        lbl_tog    = !rx_even_q;
        rx_even_d  = lbl_tog;
        cgbad      = is_invalid || (is_comma && !lbl_tog);
        cggood     = !cgbad;
        good_inc   = sat_inc2(good_cgs_q);
        case (state_q)
            ST_LOS: begin
                good_cgs_d = 2'd0;
                // A comma defines the even position from here on
                if (is_comma && signal_detect) begin
                    state_d   = ST_CD1;
                    rx_even_d = 1'b1;
                end
            end
            ST_CD1: state_d = is_data ? ST_AS1 : ST_LOS;
            ST_CD2: state_d = is_data ? ST_AS2 : ST_LOS;
            ST_CD3: state_d = (is_data && CHAIN_OK) ? ST_SA1 : ST_LOS;
            ST_AS1: begin
                if (cgbad)         state_d = ST_LOS;
                else if (is_comma) state_d = ST_CD2;
            end
            ST_AS2: begin
                if (cgbad)         state_d = ST_LOS;
                else if (is_comma) state_d = ST_CD3;
            end
            ST_SA1: begin
                good_cgs_d = 2'd0;
                if (cgbad) state_d = ST_SA2;
            end
            ST_SA2, ST_SA3, ST_SA4: begin
                good_cgs_d = 2'd0;
                if (cggood) begin
                    good_cgs_d = 2'd1;
                    state_d = (state_q == ST_SA2) ? ST_SA2A :
                              (state_q == ST_SA3) ? ST_SA3A : ST_SA4A;
                end else begin
                    state_d = (state_q == ST_SA2) ? ST_SA3 :
                              (state_q == ST_SA3) ? ST_SA4 : ST_LOS;
                end
            end
            ST_SA2A, ST_SA3A, ST_SA4A: begin
                if (cggood) begin
                    good_cgs_d = good_inc;
                    if (good_inc == GOOD_MAX) begin
                        good_cgs_d = 2'd0;
                        state_d = (state_q == ST_SA2A) ? ST_SA1 :
                                  (state_q == ST_SA3A) ? ST_SA2 : ST_SA3;
                    end
                end else begin
                    good_cgs_d = 2'd0;
                    state_d = (state_q == ST_SA2A) ? ST_SA3 :
                              (state_q == ST_SA3A) ? ST_SA4 : ST_LOS;
                end
            end
            default: state_d = ST_LOS;
        endcase
        // Losing the optical signal overrides everything else
        if (!signal_detect) begin
            state_d    = ST_LOS;
            good_cgs_d = 2'd0;
        end
        sync_d = state_d inside {ST_SA1, ST_SA2, ST_SA2A, ST_SA3, ST_SA3A, ST_SA4, ST_SA4A};
    end

    // State, counter and the aligned output group registered together
    always_ff @(posedge RX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q    <= ST_LOS;
            good_cgs_q <= 2'd0;
            rx_even_q  <= 1'b0;
            sync_q     <= 1'b0;
            sudi_q     <= 10'd0;
        end else begin
            state_q    <= state_d;
            good_cgs_q <= good_cgs_d;
            rx_even_q  <= rx_even_d;
            sync_q     <= sync_d;
            sudi_q     <= rx_code_group;
        end
    end

    assign SUDI             = sudi_q;
    assign rx_even          = rx_even_q;
    assign code_sync_status = sync_q;

endmodule

// File: tb/tb_pcs_sync.sv
// Scoreboarded bench for pcs_sync with a behavioural sync model.
module tb_pcs_sync;

    localparam logic [9:0] K285N = 10'h0FA;
    localparam logic [9:0] K285P = 10'h305;
    localparam logic [9:0] D162P = 10'h245;
    localparam logic [9:0] BADCG = 10'h000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sd = 1'b1;
    logic [9:0] cg = 10'd0;
    logic [9:0] sudi;
    logic       rx_even;
    logic       status;

    int total = 0;
    int bad = 0;

    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    bit is_d [1024];

    bit [5:0] t6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                          6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                          6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                          6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                          6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                          6'b011110, 6'b101011};
    bit [3:0] t4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

    // model state: acquisition progress or synced error level
    bit m_sync;
    int m_commas;
    bit m_wait;
    int m_level;
    int m_goods;
    bit m_even;

    always #5 clk = ~clk;

    pcs_sync dut (
        .RX_CLK           (clk),
        .mr_main_reset    (rst_n),
        .signal_detect    (sd),
        .rx_code_group    (cg),
        .SUDI             (sudi),
        .rx_even          (rx_even),
        .code_sync_status (status)
    );

    function automatic logic [9:0] enc(input logic [7:0] b, input bit rd);
        bit [5:0] s;
        bit [3:0] f;
        bit       rd1;
        int       x;
        int       y;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        s = t6[x];
        if (rd && ($countones(s) != 3 || x == 7)) s = ~s;
        rd1 = rd ^ ($countones(s) != 3);
        f = t4[y];
        if (y == 7 && ((!rd1 && (x == 17 || x == 18 || x == 20)) ||
                       (rd1 && (x == 11 || x == 13 || x == 14)))) f = 4'b0111;
        if (rd1 && ($countones(f) != 2 || y == 3)) f = ~f;
        return {s, f};
    endfunction

    function automatic logic [9:0] rand_d();
        return enc(8'($urandom), 1'($urandom));
    endfunction

    task automatic model_reset();
        m_sync = 0; m_commas = 0; m_wait = 0; m_level = 1; m_goods = 0; m_even = 0;
    endtask

    task automatic model_step(input logic [9:0] c, input bit s, output logic [11:0] e);
        bit comma, data, ctl, inv, lbl, badg;
        comma = (c == K285N) || (c == K285P);
        data  = is_d[c];
        ctl   = c inside {10'h368, 10'h097, 10'h2E8, 10'h117, 10'h3A8, 10'h057};
        inv   = !(comma || data || ctl);
        lbl   = !m_even;
        badg  = inv || (comma && !lbl);
        if (!m_sync) begin
            if (m_commas == 0) begin
                if (comma && s) begin m_commas = 1; m_wait = 1; lbl = 1; end
            end else if (m_wait) begin
                if (data) begin
                    if (m_commas == 3) begin m_sync = 1; m_level = 1; m_goods = 0; end
                    else m_wait = 0;
                end else m_commas = 0;
            end else begin
                if (badg) m_commas = 0;
                else if (comma) begin m_commas++; m_wait = 1; end
            end
        end else begin
            if (badg) begin
                m_goods = 0;
                if (m_level == 4) begin m_sync = 0; m_commas = 0; end
                else m_level++;
            end else if (m_level > 1) begin
                m_goods++;
                if (m_goods == 3) begin m_level--; m_goods = 0; end
            end
        end
        if (!s) begin m_sync = 0; m_commas = 0; end
        m_even = lbl;
        e = {c, lbl, m_sync};
    endtask

    task automatic drive(input logic [9:0] c, input bit s);
        logic [11:0] e;
        cg = c;
        sd = s;
        model_step(c, s, e);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [9:0] c, input bit s);
        @(negedge clk);
        drive(c, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            send(K285N, 1'b1);
            send(D162P, 1'b1);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Monitor: one output group per clock, compared against the scoreboard
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if ({sudi, rx_even, status} !== mon_e) begin
                bad++;
                $display("FAIL scoreboard: got sudi=%h even=%b status=%b want sudi=%h even=%b status=%b",
                         sudi, rx_even, status, mon_e[11:2], mon_e[1], mon_e[0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) is_d[i] = 0;
        for (int b = 0; b < 256; b++) begin
            is_d[enc(8'(b), 1'b0)] = 1;
            is_d[enc(8'(b), 1'b1)] = 1;
        end
        model_reset();

        // 1: reset values, then acquisition with three comma pairs
        #2 rst_n = 1'b0;
        #1;
        chk("reset_sudi", 32'(sudi), 32'd0);
        chk("reset_even", 32'(rx_even), 32'd0);
        chk("reset_status", 32'(status), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(K285N, 1'b1);
        send(D162P, 1'b1);
        send(K285N, 1'b1);
        send(D162P, 1'b1);
        send(K285N, 1'b1);
        settle();
        chk("acq_5th_status", 32'(status), 32'd0);
        chk("acq_5th_even", 32'(rx_even), 32'd1);
        send(D162P, 1'b1);
        settle();
        chk("acq_6th_status", 32'(status), 32'd1);
        idle(2);

        // 2: one bad group then three good ones keeps sync, repeatedly
        for (int k = 0; k < 5; k++) begin
            send(BADCG, 1'b1);
            for (int j = 0; j < 3; j++) send(rand_d(), 1'b1);
        end
        settle();
        chk("bad_then_3good_status", 32'(status), 32'd1);

        // bad groups separated by only two good ones escalate to loss
        for (int k = 0; k < 4; k++) begin
            send(BADCG, 1'b1);
            if (k < 3) begin send(rand_d(), 1'b1); send(rand_d(), 1'b1); end
        end
        settle();
        chk("bad_2good_loss", 32'(status), 32'd0);

        // 3: four bad groups each separated by one good one
        idle(4);
        for (int k = 0; k < 4; k++) begin
            send(BADCG, 1'b1);
            settle();
            if (k < 3) begin
                chk("bad_sep_held", 32'(status), 32'd1);
                send(rand_d(), 1'b1);
            end
        end
        chk("bad_sep_loss", 32'(status), 32'd0);

        // 4: comma in an odd slot is a bad group; K28.5 K27.7 aborts acquisition
        idle(4);
        send(rand_d(), 1'b1);
        send(K285P, 1'b1);
        settle();
        chk("odd_comma_still_sync", 32'(status), 32'd1);
        send(rand_d(), 1'b1);
        send(1'b0, 1'b0);
        send(K285N, 1'b1);
        send(10'h368, 1'b1);
        idle(2);
        send(K285N, 1'b1);
        settle();
        chk("k27_abort_status", 32'(status), 32'd0);
        send(D162P, 1'b1);
        settle();
        chk("k27_resync_status", 32'(status), 32'd1);

        // 5: one cycle of lost signal drops sync; three fresh pairs reacquire
        idle(2);
        send(D162P, 1'b0);
        settle();
        chk("sigdet_loss", 32'(status), 32'd0);
        send(K285N, 1'b1); send(D162P, 1'b1);
        send(K285N, 1'b1); send(D162P, 1'b1);
        send(K285N, 1'b1);
        settle();
        chk("sigdet_5th", 32'(status), 32'd0);
        send(D162P, 1'b1);
        settle();
        chk("sigdet_resync", 32'(status), 32'd1);

        // 6: asynchronous reset mid-stream, then resynchronize
        send(rand_d(), 1'b1);
        send(rand_d(), 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_sudi", 32'(sudi), 32'd0);
        chk("async_even", 32'(rx_even), 32'd0);
        chk("async_status", 32'(status), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(K285N, 1'b1);
        send(D162P, 1'b1);
        idle(2);
        settle();
        chk("async_resync", 32'(status), 32'd1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40) idle(1);
            else if (r < 70) begin send(rand_d(), 1'b1); send(rand_d(), 1'b1); end
            else if (r < 78) send(10'($urandom), 1'b1);
            else if (r < 84) begin
                case ($urandom_range(0, 2))
                    0: send(10'h368, 1'b1);
                    1: send(10'h2E8, 1'b1);
                    default: send(10'h3A8, 1'b1);
                endcase
            end
            else if (r < 90) send(($urandom_range(0, 1) == 0) ? K285N : K285P, 1'b1);
            else if (r < 93) send(rand_d(), 1'b0);
            else send(BADCG, 1'b1);
        end
        settle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
